hamming_encoder_tx: RTL and testbench

HAMMING_ENCODER_TX -- requirements
Module: hamming_encoder_tx

---
 rtl/hamming_encoder_tx.sv | 123 ++++++++++++
 tb/tb_hamming_encoder_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module      : hamming_encoder_tx
// Description : Hamming(7,4)+overall-parity encoder with error injection,
//               feeding a first-word-fall-through codeword FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_encoder_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] inj_mode,
    input  logic [2:0] inj_pos,
    output logic [7:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] fifo_count,
    output logic [7:0] tx_count
);

    localparam int         AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] c_DEPTH      = 5'(FIFO_DEPTH);
    localparam logic [1:0] c_INJ_SINGLE = 2'd1;
    localparam logic [1:0] c_INJ_DOUBLE = 2'd2;
    localparam logic [1:0] c_INJ_PERIOD = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic [7:0]    r_tx_count;
    logic [1:0]    r_acc_cnt;
    logic [7:0]    r_out_code;
    logic          r_out_valid;

    logic          w_push;
    logic          w_pop;
    logic          w_c0, w_c1, w_c2, w_call;
    logic [7:0]    w_clean;
    logic [7:0]    w_flip;
    logic [2:0]    w_pos_inc;
    logic [7:0]    w_word;
    logic [AW-1:0] w_rd_ptr_next;
    logic [4:0]    w_count_next;
    logic [7:0]    w_head_next;

    assign in_ready   = (r_count < c_DEPTH);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = r_out_valid && out_ready;

    assign w_c0    = in_data[0] ^ in_data[1] ^ in_data[3];
    assign w_c1    = in_data[0] ^ in_data[2] ^ in_data[3];
    assign w_c2    = in_data[1] ^ in_data[2] ^ in_data[3];
    assign w_call  = ^{in_data[3:1], w_c2, in_data[0], w_c1, w_c0};
    assign w_clean = {w_call, in_data[3:1], w_c2, in_data[0], w_c1, w_c0};

    assign w_pos_inc = inj_pos + 3'd1;

    always_comb begin
        w_flip = 8'h00;
        case (inj_mode)
            c_INJ_SINGLE: w_flip = 8'h01 << inj_pos;
            c_INJ_DOUBLE: w_flip = (8'h01 << inj_pos) | (8'h01 << w_pos_inc);
            c_INJ_PERIOD: if (r_acc_cnt == 2'd3) w_flip = 8'h01 << inj_pos;
            default:      w_flip = 8'h00;
        endcase
    end

    assign w_word = w_clean ^ w_flip;

    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 5'd1;
        else if (!w_push && w_pop)
            w_count_next = r_count - 5'd1;
    end

    // The new word is the head only when it lands in the slot the read pointer moves to.
    assign w_head_next = (w_push && (r_wr_ptr == w_rd_ptr_next)) ? w_word : r_mem[w_rd_ptr_next];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= 5'd0;
            r_tx_count  <= 8'd0;
            r_acc_cnt   <= 2'd0;
            r_out_code  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_acc_cnt <= r_acc_cnt + 2'd1;
            end
            if (w_pop)
                r_tx_count <= r_tx_count + 8'd1;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != 5'd0);
            if (w_count_next != 5'd0)
                r_out_code <= w_head_next;
        end
    end

    assign out_code   = r_out_code;
    assign out_valid  = r_out_valid;
    assign fifo_count = r_count;
    assign tx_count   = r_tx_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_encoder_tx
// Description : Bench for hamming_encoder_tx: queue-based reference model,
//               per-cycle compare, directed literal cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_encoder_tx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] inj_mode = 2'd0;
    logic [2:0] inj_pos = 3'd0;
    logic [7:0] out_code;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] fifo_count;
    logic [7:0] tx_count;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    logic [7:0] mq[$];
    int         cq[$];
    int         m_acc  = 0;
    int         m_tx   = 0;
    logic [7:0] m_last = 8'h00;

    hamming_encoder_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inj_mode   (inj_mode),
        .inj_pos    (inj_pos),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // Classic Hamming layout: position k (1..7) is codeword bit k-1; parity sits at powers of two.
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] pos;
        logic [7:0] code;
        pos = 8'h00;
        pos[3] = d[0]; pos[5] = d[1]; pos[6] = d[2]; pos[7] = d[3];
        for (int j = 0; j < 3; j++) begin
            logic p;
            p = 1'b0;
            for (int k = 3; k < 8; k++)
                if (k != 4 && ((k >> j) & 1) == 1) p = p ^ pos[k];
            pos[1 << j] = p;
        end
        for (int i = 0; i < 7; i++) code[i] = pos[i+1];
        code[7] = ^code[6:0];
        return code;
    endfunction

    // 0 = clean, 1 = single-bit error, 2 = double-bit error
    function automatic int classify(input logic [7:0] c);
        int syn;
        syn = 0;
        for (int i = 0; i < 7; i++) if (c[i]) syn = syn ^ (i + 1);
        if (^c) return 1;
        return (syn == 0) ? 0 : 2;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete(); cq.delete();
            m_acc = 0; m_tx = 0; m_last = 8'h00;
        end else begin
            bit         dlv, acc;
            logic [7:0] w;
            int         nflip;
            dlv = (mq.size() != 0) && out_ready;
            acc = in_valid && (mq.size() < DEPTH);
            w = 8'h00; nflip = 0;
            if (acc) begin
                w = enc(in_data);
                case (inj_mode)
                    2'd1: begin w[inj_pos] = ~w[inj_pos]; nflip = 1; end
                    2'd2: begin
                        w[inj_pos] = ~w[inj_pos];
                        w[(inj_pos + 1) % 8] = ~w[(inj_pos + 1) % 8];
                        nflip = 2;
                    end
                    2'd3: if (m_acc == 3) begin w[inj_pos] = ~w[inj_pos]; nflip = 1; end
                    default: ;
                endcase
                m_acc = (m_acc + 1) % 4;
            end
            if (dlv) begin
                void'(mq.pop_front()); void'(cq.pop_front());
                m_tx = (m_tx + 1) % 256;
            end
            if (acc) begin mq.push_back(w); cq.push_back(nflip); end
            if (mq.size() != 0) m_last = mq[0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("out_code", int'(out_code), int'((mq.size() != 0) ? mq[0] : m_last));
            chk("tx_count", int'(tx_count), m_tx);
            if (out_valid && mq.size() != 0)
                chk("decode_class", classify(out_code), cq[0]);
        end
    end

    task automatic step(input logic v, input logic [3:0] d, input logic [1:0] m,
                        input logic [2:0] p, input logic ordy, input logic rn);
        in_valid = v; in_data = d; inj_mode = m; inj_pos = p;
        out_ready = ordy; rst_n = rn;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 4'h0, 2'd0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        do_reset();
        chk_en = 1'b1;
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_code", int'(out_code), 0);
        chk("rst_tx_count", int'(tx_count), 0);

        // Clean encoding, delivered as fast as produced
        step(1'b1, 4'hB, 2'd0, 3'd0, 1'b1, 1'b1); chk("enc_B", int'(out_code), 'h55);
        step(1'b1, 4'h0, 2'd0, 3'd0, 1'b1, 1'b1); chk("enc_0", int'(out_code), 'h00);
        step(1'b1, 4'hF, 2'd0, 3'd0, 1'b1, 1'b1); chk("enc_F", int'(out_code), 'hFF);
        step(1'b1, 4'hB, 2'd1, 3'd0, 1'b1, 1'b1); chk("inj_single", int'(out_code), 'h54);
        step(1'b1, 4'h0, 2'd2, 3'd7, 1'b1, 1'b1); chk("inj_double_wrap", int'(out_code), 'h81);
        step(1'b0, 4'h0, 2'd0, 3'd0, 1'b1, 1'b1);

        // Periodic injection from a fresh accept counter
        do_reset();
        step(1'b1, 4'h0, 2'd3, 3'd2, 1'b1, 1'b1); chk("inj_per_1", int'(out_code), 'h00);
        step(1'b1, 4'h0, 2'd3, 3'd2, 1'b1, 1'b1); chk("inj_per_2", int'(out_code), 'h00);
        step(1'b1, 4'h0, 2'd3, 3'd2, 1'b1, 1'b1); chk("inj_per_3", int'(out_code), 'h00);
        step(1'b1, 4'h0, 2'd3, 3'd2, 1'b1, 1'b1); chk("inj_per_4", int'(out_code), 'h04);

        // Backpressure: six offers into a four-deep FIFO
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), 2'd0, 3'd0, 1'b0, 1'b1);
        chk("bp_fifo_count", int'(fifo_count), 4);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_head", int'(out_code), 'h87);
        step(1'b0, 4'h0, 2'd0, 3'd0, 1'b1, 1'b1);
        chk("bp_second", int'(out_code), 'h99);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 2'd0, 3'd0, 1'b1, 1'b1);
        chk("bp_tx_count", int'(tx_count), 4);
        chk("bp_drained", int'(out_valid), 0);

        // Full FIFO with simultaneous offer and drain
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 7), 2'd0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 4'hA, 2'd0, 3'd0, 1'b1, 1'b1);
        chk("full_no_accept", int'(fifo_count), 3);
        step(1'b1, 4'hC, 2'd0, 3'd0, 1'b1, 1'b1);
        chk("simul_count", int'(fifo_count), 3);

        // Reset with words buffered and an offer in the reset cycle
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 2'd1, 3'(i), 1'b0, 1'b1);
        step(1'b1, 4'h9, 2'd0, 3'd0, 1'b1, 1'b0);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_tx", int'(tx_count), 0);
        chk("midrst_code", int'(out_code), 0);
        step(1'b1, 4'hB, 2'd0, 3'd0, 1'b0, 1'b1);
        chk("post_rst_code", int'(out_code), 'h55);
        chk("post_rst_valid", int'(out_valid), 1);

        // Random traffic in every injection mode; long enough for tx_count to wrap
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, 4'($urandom), 2'($urandom), 3'($urandom),
                 ($urandom % 4) != 0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 2'd0, 3'd0, 1'b1, 1'b1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
